// File: rtl/add_reg_driver.sv
// add_reg_driver: stimulus driver and checker for a registered adder.
// After a start request it waits WARMUP cycles, drives NUM_VEC operand
// pairs (a fixed first vector, then LFSR-derived vectors), and compares
// the DUT sum against an internally delayed reference sum.
// Compile-time option: define ADD_REG_DRIVER_TRACE_EN to print one trace
// line per comparison. The default build leaves it undefined and compiles
// no display statements.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_WARM  | settle time before the first vector, WARMUP cycles (min 1)
// S_RUN   | one vector per cycle with en=1, NUM_VEC cycles
// S_DRAIN | en=0, waiting LATENCY cycles for the last results
// S_DONE  | results held (done/pass/err_count) until the next start
module add_reg_driver #(
   parameter int WIDTH   = 8,
   parameter int WARMUP  = 5000,
   parameter int NUM_VEC = 16,
   parameter int LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             en,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WARM  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Timer reload values; a timer value of 0 marks the last cycle of a state.
   localparam logic [31:0] WARM_LD = (WARMUP > 0) ? 32'(WARMUP - 1) : 32'd0;
   localparam logic [31:0] RUN_LD  = 32'(NUM_VEC - 1);
   localparam logic [31:0] DRN_LD  = 32'(LATENCY - 1);

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // First vector: a = 8, b = -10, both truncated to WIDTH bits.
   localparam logic [7:0]  V0_A      = 8'h08;
   localparam logic [7:0]  V0_B      = 8'hF6;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_tmr;
   logic [31:0]      w_tmr_nxt;
   logic             w_launch;
   logic             r_first;
   logic [15:0]      r_lfsr;
   logic             w_lfsr_fb;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_yr [LATENCY];
   logic [LATENCY-1:0] r_vld;
   logic             w_cmp;
   logic             w_mis;

   // Next-state, timer and Moore outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_launch    = 1'b0;
      en          = 1'b0;
      a           = '0;
      b           = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            done = (r_state == S_DONE);
            if (start) begin
               w_state_nxt = S_WARM;
               w_tmr_nxt   = WARM_LD;
               w_launch    = 1'b1;
            end
         end
         S_WARM: begin
            busy = 1'b1;
            if (r_tmr == 32'd0) begin
               w_state_nxt = S_RUN;
               w_tmr_nxt   = RUN_LD;
            end else begin
               w_tmr_nxt = r_tmr - 32'd1;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            en   = 1'b1;
            if (r_first) begin
               a = V0_A[WIDTH-1:0];
               b = V0_B[WIDTH-1:0];
            end else begin
               a = r_lfsr[WIDTH-1:0];
               b = r_lfsr[8 +: WIDTH];
            end
            if (r_tmr == 32'd0) begin
               w_state_nxt = S_DRAIN;
               w_tmr_nxt   = DRN_LD;
            end else begin
               w_tmr_nxt = r_tmr - 32'd1;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (r_tmr == 32'd0) begin
               w_state_nxt = S_DONE;
               w_tmr_nxt   = 32'd0;
            end else begin
               w_tmr_nxt = r_tmr - 32'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tmr_nxt   = 32'd0;
         end
      endcase
   end

   // State register and phase timer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_tmr   <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
      end
   end

   // Marks the first RUN cycle, which carries the fixed vector 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_first <= 1'b0;
      end else begin
         r_first <= (r_state == S_WARM) && (w_state_nxt == S_RUN);
      end
   end

   assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   // Fibonacci LFSR (taps 16,14,13,11); reseeded at every launch, held
   // during vector 0 so vector 1 uses the seed itself.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_lfsr <= LFSR_SEED;
      end else if (w_launch) begin
         r_lfsr <= LFSR_SEED;
      end else if ((r_state == S_RUN) && !r_first) begin
         r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      end
   end

   assign w_sum = a + b;

   // Reference pipeline: sum and valid delayed by LATENCY cycles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_yr[i]  <= '0;
            r_vld[i] <= 1'b0;
         end
      end else if (w_launch) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_yr[i]  <= '0;
            r_vld[i] <= 1'b0;
         end
      end else begin
         r_yr[0]  <= w_sum;
         r_vld[0] <= en;
         for (int i = 1; i < LATENCY; i++) begin
            r_yr[i]  <= r_yr[i-1];
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   assign w_cmp = r_vld[LATENCY-1];
   assign w_mis = w_cmp && (y != r_yr[LATENCY-1]);

   // Saturating mismatch counter, cleared at every launch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_count <= 16'd0;
      end else if (w_launch) begin
         err_count <= 16'd0;
      end else if (w_mis && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end

   assign pass = done && (err_count == 16'd0);

`ifdef ADD_REG_DRIVER_TRACE_EN
   logic [31:0]      r_cyc;
   logic [WIDTH-1:0] r_ta [LATENCY];
   logic [WIDTH-1:0] r_tb [LATENCY];

   // Trace-only: cycles since start and operands aligned with the reference.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cyc <= 32'd0;
         for (int i = 0; i < LATENCY; i++) begin
            r_ta[i] <= '0;
            r_tb[i] <= '0;
         end
      end else begin
         if (w_launch) begin
            r_cyc <= 32'd1;
         end else if (busy) begin
            r_cyc <= r_cyc + 32'd1;
         end
         r_ta[0] <= a;
         r_tb[0] <= b;
         for (int i = 1; i < LATENCY; i++) begin
            r_ta[i] <= r_ta[i-1];
            r_tb[i] <= r_tb[i-1];
         end
      end
   end

   // Trace-only: one line per comparison, signed decimal values.
   always_ff @(posedge clock) begin
      if (reset && w_cmp) begin
         $display("cycle:%0d a:%0d b:%0d y:%0d yr:%0d", r_cyc,
                  $signed(r_ta[LATENCY-1]), $signed(r_tb[LATENCY-1]),
                  $signed(y), $signed(r_yr[LATENCY-1]));
      end
   end
`endif

endmodule

// File: tb/tb_add_reg_driver.sv
// Bench for add_reg_driver: three driver instances with behavioural adder
// models (1-cycle, 2-cycle, 4-bit), checked against hand-computed vectors.
module tb_add_reg_driver;

   logic       clk;
   logic       rst_n;
   logic       start0, start1, start2;
   logic [1:0] m0;

   logic [7:0]  a0, b0, y0;
   logic        en0, busy0, done0, pass0;
   logic [15:0] err0;
   logic [7:0]  a1, b1, y1;
   logic        en1, busy1, done1, pass1;
   logic [15:0] err1;
   logic [3:0]  a2, b2, y2;
   logic        en2, busy2, done2, pass2;
   logic [15:0] err2;

   logic [7:0] y0_d1, y0_d2, y1_d1, y1_d2;
   logic [3:0] y2_d1;

   int n_cmp = 0;
   int n_bad = 0;

   add_reg_driver #(.WIDTH(8), .WARMUP(10), .NUM_VEC(16), .LATENCY(1)) u0 (
      .clock(clk), .reset(rst_n), .start(start0), .a(a0), .b(b0), .en(en0),
      .y(y0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0));

   add_reg_driver #(.WIDTH(8), .WARMUP(2), .NUM_VEC(8), .LATENCY(2)) u1 (
      .clock(clk), .reset(rst_n), .start(start1), .a(a1), .b(b1), .en(en1),
      .y(y1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1));

   add_reg_driver #(.WIDTH(4), .WARMUP(0), .NUM_VEC(6), .LATENCY(1)) u2 (
      .clock(clk), .reset(rst_n), .start(start2), .a(a2), .b(b2), .en(en2),
      .y(y2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural registered adders standing in for the device under test.
   always @(posedge clk) begin
      y0_d1 <= a0 + b0;
      y0_d2 <= y0_d1;
      y1_d1 <= a1 + b1;
      y1_d2 <= y1_d1;
      y2_d1 <= a2 + b2;
   end

   // m0: 0 = correct 1-cycle adder, 1 = stuck at zero, 2 = 2-cycle adder
   assign y0 = (m0 == 2'd1) ? 8'h00 : (m0 == 2'd2) ? y0_d2 : y0_d1;
   assign y1 = y1_d2;
   assign y2 = y2_d1;

   typedef struct {
      int         cyc;
      logic       en;
      logic       busy;
      logic       done;
      logic [7:0] a;
      logic [7:0] b;
   } pt_t;

   pt_t        ptab[9];
   logic [7:0] va[16];
   logic [7:0] vb[16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // One full u0 run: records vector errors, first en cycle, en count and
   // the cycle done first appears; optionally pulses start at inj_cyc.
   task automatic run_u0(input logic [1:0] mode, input int inj_cyc,
                         output int seq_err, output int first_en,
                         output int n_en, output int done_cyc,
                         output logic clr_ok);
      int c;
      m0       = mode;
      seq_err  = 0;
      first_en = -1;
      n_en     = 0;
      done_cyc = -1;
      start0   = 1'b1;
      tick();
      start0   = 1'b0;
      clr_ok   = !done0 && !pass0 && (err0 == 16'd0);
      c = 1;
      while (c <= 200) begin
         if (en0) begin
            if (first_en < 0) first_en = c;
            if (n_en >= 16) seq_err++;
            else if ((a0 != va[n_en]) || (b0 != vb[n_en])) seq_err++;
            n_en++;
         end else if ((a0 != 8'h00) || (b0 != 8'h00)) begin
            seq_err++;
         end
         if (done0) begin
            done_cyc = c;
            break;
         end
         start0 = (c == inj_cyc);
         tick();
         c++;
      end
      start0 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c, se, fe, ne, dc;
      logic co;

      va = '{8'h08, 8'hE1, 8'h70, 8'h38, 8'h9C, 8'hCE, 8'h67, 8'hB3,
             8'h59, 8'hAC, 8'h56, 8'hAB, 8'h55, 8'h2A, 8'h15, 8'h8A};
      vb = '{8'hF6, 8'hAC, 8'h56, 8'hAB, 8'h55, 8'h2A, 8'h15, 8'h8A,
             8'h45, 8'h22, 8'h91, 8'hC8, 8'hE4, 8'h72, 8'h39, 8'h1C};

      ptab[0] = '{1,  1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
      ptab[1] = '{10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
      ptab[2] = '{11, 1'b1, 1'b1, 1'b0, 8'h08, 8'hF6};
      ptab[3] = '{12, 1'b1, 1'b1, 1'b0, 8'hE1, 8'hAC};
      ptab[4] = '{16, 1'b1, 1'b1, 1'b0, 8'hCE, 8'h2A};
      ptab[5] = '{26, 1'b1, 1'b1, 1'b0, 8'h8A, 8'h1C};
      ptab[6] = '{27, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
      ptab[7] = '{28, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
      ptab[8] = '{29, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};

      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      m0     = 2'd0;
      repeat (3) tick();

      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_pass", 32'(pass0), 32'd0);
      chk("rst_en",   32'(en0),   32'd0);
      chk("rst_ab",   {16'd0, a0, b0}, 32'd0);
      chk("rst_err",  32'(err0),  32'd0);

      rst_n = 1'b1;
      repeat (2) tick();

      // Full run, phase checks from the table.
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      c = 1;
      for (int i = 0; i < 9; i++) begin
         while (c < ptab[i].cyc) begin
            tick();
            c++;
         end
         chk($sformatf("ph%0d_en", ptab[i].cyc),   32'(en0),   32'(ptab[i].en));
         chk($sformatf("ph%0d_busy", ptab[i].cyc), 32'(busy0), 32'(ptab[i].busy));
         chk($sformatf("ph%0d_done", ptab[i].cyc), 32'(done0), 32'(ptab[i].done));
         chk($sformatf("ph%0d_a", ptab[i].cyc),    32'(a0),    32'(ptab[i].a));
         chk($sformatf("ph%0d_b", ptab[i].cyc),    32'(b0),    32'(ptab[i].b));
      end
      chk("run1_err",  32'(err0),  32'd0);
      chk("run1_pass", 32'(pass0), 32'd1);

      // Restart from DONE with the full sequence and a correct adder.
      run_u0(2'd0, -1, se, fe, ne, dc, co);
      chk("run2_seq",   32'(se), 32'd0);
      chk("run2_first", 32'(fe), 32'd11);
      chk("run2_nen",   32'(ne), 32'd16);
      chk("run2_done",  32'(dc), 32'd28);
      chk("run2_pass",  32'(pass0), 32'd1);

      // Adder stuck at zero: every comparison must miss.
      run_u0(2'd1, -1, se, fe, ne, dc, co);
      chk("zero_err",  32'(err0),  32'd16);
      chk("zero_pass", 32'(pass0), 32'd0);
      chk("zero_done", 32'(done0), 32'd1);

      // 2-cycle adder against LATENCY=1; restart must clear previous results.
      run_u0(2'd2, -1, se, fe, ne, dc, co);
      chk("lat_clr",     32'(co), 32'd1);
      chk("lat_err_nz",  32'(err0 != 16'd0), 32'd1);
      chk("lat_pass",    32'(pass0), 32'd0);

      // Reset during vector 5 aborts immediately.
      m0     = 2'd0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      c = 1;
      while (c < 16) begin
         tick();
         c++;
      end
      chk("v5_en", 32'(en0), 32'd1);
      chk("v5_a",  32'(a0),  32'hCE);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_en",   32'(en0),   32'd0);
      chk("abort_err",  32'(err0),  32'd0);
      chk("abort_a",    32'(a0),    32'd0);
      chk("abort_done", 32'(done0), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      chk("idle_busy", 32'(busy0), 32'd0);
      chk("idle_done", 32'(done0), 32'd0);

      // New start after reset, with a start pulse during RUN that is ignored.
      run_u0(2'd0, 14, se, fe, ne, dc, co);
      chk("ign_seq",  32'(se), 32'd0);
      chk("ign_nen",  32'(ne), 32'd16);
      chk("ign_done", 32'(dc), 32'd28);
      chk("ign_pass", 32'(pass0), 32'd1);

      // Start accepted in DONE repeats the identical sequence.
      run_u0(2'd0, -1, se, fe, ne, dc, co);
      chk("rep_seq",   32'(se), 32'd0);
      chk("rep_first", 32'(fe), 32'd11);
      chk("rep_pass",  32'(pass0), 32'd1);

      // LATENCY=2 driver with a matching 2-cycle adder.
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      c  = 1;
      dc = -1;
      while (c <= 100) begin
         if (done1) begin
            dc = c;
            break;
         end
         tick();
         c++;
      end
      chk("l2_done", 32'(dc), 32'd13);
      chk("l2_err",  32'(err1), 32'd0);
      chk("l2_pass", 32'(pass1), 32'd1);

      // WIDTH=4, WARMUP=0: truncated vector 0 and wrapping sums.
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      chk("w4_warm_busy", 32'(busy2), 32'd1);
      chk("w4_warm_en",   32'(en2),   32'd0);
      tick();
      chk("w4_v0", {24'd0, a2, b2}, 32'h86);
      tick();
      chk("w4_v1", {24'd0, a2, b2}, 32'h1C);
      repeat (2) tick();
      chk("w4_v3", {24'd0, a2, b2}, 32'h8B);
      tick();
      chk("w4_v4", {24'd0, a2, b2}, 32'hC5);
      c  = 6;
      dc = -1;
      while (c <= 100) begin
         if (done2) begin
            dc = c;
            break;
         end
         tick();
         c++;
      end
      chk("w4_done", 32'(dc), 32'd9);
      chk("w4_err",  32'(err2), 32'd0);
      chk("w4_pass", 32'(pass2), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/add_reg_driver.md
ADD_REG_DRIVER -- requirements
Module: add_reg_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal range 1..8.
REQ-002 SHALL have parameter WARMUP, default 5000, idle cycles before the first vector (GSR settle).
REQ-003 SHALL have parameter NUM_VEC, default 16, vectors per run; legal range 1..65535.
REQ-004 SHALL have parameter LATENCY, default 1, DUT cycles from a/b/en to y; legal range 1..4.
REQ-005 Ports SHALL be: clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle run request.
REQ-008 a  output  WIDTH  operand A to DUT.
REQ-009 b  output  WIDTH  operand B to DUT.
REQ-010 en  output  1  DUT register enable.
REQ-011 y  input  WIDTH  registered DUT sum.
REQ-012 busy  output  1  run in progress.
REQ-013 done  output  1  run complete, sticky until next start or reset.
REQ-014 pass  output  1  done and zero mismatches.
REQ-015 err_count  output  16  mismatch count.

Function
REQ-016 FSM states SHALL be IDLE, WARM, RUN, DRAIN, DONE.
REQ-017 IDLE->WARM on start; WARM->RUN after exactly WARMUP cycles in WARM (WARMUP=0: next cycle).
REQ-018 RUN SHALL last exactly NUM_VEC cycles, driving one vector per cycle with en=1.
REQ-019 RUN->DRAIN after the last vector; DRAIN SHALL last LATENCY cycles with en=0; DRAIN->DONE.
REQ-020 DONE->WARM on start, clearing done, pass, err_count and reseeding the generator.
REQ-021 start SHALL be ignored in WARM, RUN, DRAIN.
REQ-022 a, b SHALL be 0 and en SHALL be 0 in every state except RUN.
REQ-023 Vector 0 SHALL be a=8, b=-10 (two's complement, truncated to WIDTH).
REQ-024 Vectors 1..NUM_VEC-1: a=lfsr[WIDTH-1:0], b=lfsr[15:8] truncated to WIDTH; 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on entering WARM, one step per RUN cycle after vector 0.
REQ-025 Expected yr SHALL be (a+b) mod 2^WIDTH, carried with a valid bit through a LATENCY-deep pipeline.
REQ-026 When the delayed valid is 1, y SHALL be compared to delayed yr; inequality SHALL increment err_count.
REQ-027 err_count SHALL saturate at 16'hFFFF.
REQ-028 The last comparison SHALL occur in the final DRAIN cycle; no comparison outside RUN/DRAIN.
REQ-029 busy=1 in WARM, RUN, DRAIN; done=1 only in DONE; pass=done and err_count==0.

Reset
REQ-030 reset low SHALL immediately force IDLE, a=b=0, en=0, busy=0, done=0, pass=0, err_count=0, pipeline valid bits 0, LFSR=seed.
REQ-031 reset asserted mid-run SHALL abort the run with no done pulse; reset release SHALL require a new start.

Configuration
REQ-032 Macro ADD_REG_DRIVER_TRACE_EN defined: each comparison SHALL $display "cycle:<n> a:<a> b:<b> y:<y> yr:<yr>" with signed decimal values, n = cycles since start.
REQ-033 Macro undefined: no display statements compiled; function identical.

Verification
REQ-034 Correct DUT (LATENCY=1), WARMUP=10, NUM_VEC=16, start pulsed -> en high for exactly 16 cycles starting cycle 11 after start, done after 27 cycles, err_count=0, pass=1.
REQ-035 Vector 0 check: first RUN cycle a=8'h08, b=8'hF6; one cycle later y=8'hFE expected and compared.
REQ-036 DUT model forcing y=0 -> err_count=16, pass=0, done=1.
REQ-037 DUT with 2-cycle latency while LATENCY=2 -> pass=1; same DUT with LATENCY=1 -> err_count>0.
REQ-038 reset low during RUN vector 5 -> same cycle busy=0, en=0, err_count=0; start ignored mid-run, accepted in DONE and repeats identical vector sequence.
REQ-039 WIDTH=4: vector 0 a=4'h8, b=4'h6, expected 4'hE; wrap 4'hF+4'h1 compared as 4'h0.
